// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   - sub_state_e : controller states (IDLE, RUN, DONE)
//   - cnt_w()     : bit-counter width for a given operand width, never below 1
//   - CNT_W_MIN   : smallest counter width handed out by cnt_w()
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  localparam int CNT_W_MIN = 1;

  // Width of a counter that must index bits 0 .. width-1. A one-bit operand
  // still gets a one-bit counter so the vector is never zero width.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < CNT_W_MIN) begin
      w = CNT_W_MIN;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// -----------------------------------------------------------------------------
// sheffer / full_subtractor
//   sheffer         : a single two-input NAND cell (the only primitive used).
//     a, b  in  operands
//     y     out ~(a & b)
//   full_subtractor : one-bit full subtractor built purely from sheffer cells.
//     a     in  minuend bit
//     b     in  subtrahend bit
//     bin   in  borrow in
//     d     out difference bit  a ^ b ^ bin
//     bout  out borrow out      (~a & b) | (~(a ^ b) & bin)
// -----------------------------------------------------------------------------
module sheffer (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic n1, n2, n3, x;
  logic m1, m2, m3;

  // First XOR stage: x = a ^ b
  sheffer u_n1 (.a(a),  .b(b),  .y(n1));
  sheffer u_n2 (.a(a),  .b(n1), .y(n2));
  sheffer u_n3 (.a(b),  .b(n1), .y(n3));
  sheffer u_x  (.a(n2), .b(n3), .y(x));

  // Second XOR stage: d = x ^ bin
  sheffer u_m1 (.a(x),   .b(bin), .y(m1));
  sheffer u_m2 (.a(x),   .b(m1),  .y(m2));
  sheffer u_m3 (.a(bin), .b(m1),  .y(m3));
  sheffer u_d  (.a(m2),  .b(m3),  .y(d));

  // Borrow reuses the XOR internals: n3 = ~(~a & b) and m3 = ~(~x & bin),
  // so their NAND is exactly (~a & b) | (~x & bin).
  sheffer u_bo (.a(n3), .b(m3), .y(bout));

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock.
//   A start in IDLE or DONE latches the operands; WIDTH RUN cycles follow, then
//   a one-cycle DONE in which the result becomes visible.
//
//   Parameters
//     WIDTH       operand/result width (>= 1)
//   Ports
//     clk         in   rising-edge clock
//     rst_n       in   asynchronous active-low reset
//     start       in   begin a subtraction (accepted in IDLE or DONE)
//     a, b        in   minuend / subtrahend, sampled when start is accepted
//     busy        out  high while in RUN
//     done        out  one-cycle pulse, diff/borrow_out just updated
//     diff        out  (a - b) mod 2**WIDTH, held until the next completion
//     borrow_out  out  1 iff a < b, held with diff
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_sr_q,  a_sr_d;
  logic [WIDTH-1:0] b_sr_q,  b_sr_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             br_q,    br_d;
  logic             bout_q,  bout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts the first bit
  // computed (the LSB) has arrived at position 0. Written this way so that
  // WIDTH=1 needs no special slice.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fs_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_shift;
        br_d   = fs_bout;
        cnt_d  = cnt_q + 1'b1;
        // Publish directly from the final bit so outputs never see a partial
        // result and no extra cycle is spent copying res_q.
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = res_shift;
          bout_d  = fs_bout;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
